// File: rtl/beat_deserializer_if.sv
// Handshake bundle for the beat deserializer: beat input channel, record output channel, status.
interface beat_deserializer_if #(
  parameter int unsigned BEAT_WIDTH = 8,
  parameter int unsigned BEATS      = 4
);

  localparam int unsigned REC_W = BEAT_WIDTH * BEATS;
  localparam int unsigned CNT_W = $clog2(BEATS);

  // Beat input channel
  logic                  i_valid;
  logic                  o_ready;
  logic [BEAT_WIDTH-1:0] i_data;
  logic                  i_last;

  // Record output channel
  logic                  o_valid;
  logic                  i_ready;
  logic [REC_W-1:0]      o_data;

  // Status
  logic                  o_error;
  logic [CNT_W-1:0]      o_count;

  // Deserializer side
  modport slave (
    input  i_valid,
    input  i_data,
    input  i_last,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data,
    output o_error,
    output o_count
  );

  // Link receiver / record consumer side
  modport master (
    output i_valid,
    output i_data,
    output i_last,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_error,
    input  o_count
  );

endinterface

// File: rtl/beat_deserializer.sv
// Reassembles BEATS beats of BEAT_WIDTH bits into one record, flags short/long frames
// and resynchronises on the next i_last after a long frame.
module beat_deserializer #(
  parameter int unsigned BEAT_WIDTH = 8,
  parameter int unsigned BEATS      = 4,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  beat_deserializer_if.slave bus
);

  localparam int unsigned     REC_W    = BEAT_WIDTH * BEATS;
  localparam int unsigned     CNT_W    = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BEATS - 1);

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_DRAIN   = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [REC_W-1:0]   asm_q, asm_d;
  logic [REC_W-1:0]   out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               error_q, error_d;

  logic               ready_c;
  logic               accept_c;
  logic               pop_c;
  logic               at_last_c;

  // Place one beat into its slot of the assembly register, honouring beat order.
  function automatic logic [REC_W-1:0] write_slot(
    input logic [REC_W-1:0]      rec,
    input logic [CNT_W-1:0]      idx,
    input logic [BEAT_WIDTH-1:0] beat
  );
    logic [REC_W-1:0] r;
    r = rec;
    for (int unsigned k = 0; k < BEATS; k++) begin
      if (idx == CNT_W'(k)) begin
        if (MSB_FIRST) begin
          r[(BEATS - 1 - k) * BEAT_WIDTH +: BEAT_WIDTH] = beat;
        end else begin
          r[k * BEAT_WIDTH +: BEAT_WIDTH] = beat;
        end
      end
    end
    return r;
  endfunction

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: a long frame drains until its i_last, then collection resumes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COLLECT: begin
        if (accept_c && at_last_c && !bus.i_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (accept_c && bus.i_last) begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  // Handshake outputs: only the record-completing beat can stall, and only behind a held record
  always_comb begin
    at_last_c = (count_q == LAST_IDX);
    ready_c   = 1'b1;
    if ((state_q == S_COLLECT) && at_last_c && out_valid_q && !bus.i_ready) begin
      ready_c = 1'b0;
    end
    accept_c  = bus.i_valid && ready_c;
    pop_c     = out_valid_q && bus.i_ready;
  end

  // Datapath next values: beat storage, record hand-off and framing-error detection
  always_comb begin
    count_d     = count_q;
    asm_d       = asm_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    error_d     = 1'b0;

    if (pop_c) begin
      out_valid_d = 1'b0;
    end

    if ((state_q == S_COLLECT) && accept_c) begin
      if (!at_last_c) begin
        if (bus.i_last) begin
          // Short frame: partial record abandoned
          count_d = '0;
          error_d = 1'b1;
        end else begin
          asm_d   = write_slot(asm_q, count_q, bus.i_data);
          count_d = count_q + CNT_W'(1);
        end
      end else begin
        // Record complete; a missing i_last marks a long frame
        asm_d       = write_slot(asm_q, count_q, bus.i_data);
        out_data_d  = asm_d;
        out_valid_d = 1'b1;
        count_d     = '0;
        error_d     = !bus.i_last;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      count_q     <= '0;
      asm_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      count_q     <= count_d;
      asm_q       <= asm_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
    end
  end

  assign bus.o_ready = ready_c;
  assign bus.o_valid = out_valid_q;
  assign bus.o_data  = out_data_q;
  assign bus.o_error = error_q;
  assign bus.o_count = count_q;

endmodule

// File: tb/tb_beat_deserializer.sv
// Directed bench: LSB-first and MSB-first instances driven in lockstep.
module tb_beat_deserializer;

  logic       clk;
  logic       rst;
  logic       v;
  logic [7:0] d;
  logic       l;
  logic       r;
  logic       rdy_seen;

  int n_checks = 0;
  int n_fail   = 0;

  beat_deserializer_if #(.BEAT_WIDTH(8), .BEATS(4)) bus_l ();
  beat_deserializer_if #(.BEAT_WIDTH(8), .BEATS(4)) bus_m ();

  assign bus_l.i_valid = v;
  assign bus_l.i_data  = d;
  assign bus_l.i_last  = l;
  assign bus_l.i_ready = r;
  assign bus_m.i_valid = v;
  assign bus_m.i_data  = d;
  assign bus_m.i_last  = l;
  assign bus_m.i_ready = r;

  beat_deserializer #(.BEAT_WIDTH(8), .BEATS(4), .MSB_FIRST(1'b0)) dut_l (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_l)
  );

  beat_deserializer #(.BEAT_WIDTH(8), .BEATS(4), .MSB_FIRST(1'b1)) dut_m (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare observed vs expected, count, report mismatches
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Record held by both instances, in their respective beat orders
  task automatic check_rec(input string tag, input logic [31:0] exp);
    check_eq({tag, "_valid"}, 64'(bus_l.o_valid), 64'd1);
    check_eq({tag, "_lsb"}, 64'(bus_l.o_data), 64'(exp));
    check_eq({tag, "_msb"}, 64'(bus_m.o_data), 64'(bswap(exp)));
  endtask

  // Apply inputs at a falling edge, note o_ready, advance to the next falling edge
  task automatic step(input logic vv, input logic [7:0] dd, input logic ll, input logic rr);
    v = vv; d = dd; l = ll; r = rr;
    #1;
    rdy_seen = bus_l.o_ready;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    v = 1'b0; d = 8'h00; l = 1'b0; r = 1'b1; rst = 1'b1;
    @(negedge clk);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Reset values
    check_eq("rst_valid", 64'(bus_l.o_valid), 64'd0);
    check_eq("rst_data",  64'(bus_l.o_data),  64'd0);
    check_eq("rst_error", 64'(bus_l.o_error), 64'd0);
    check_eq("rst_count", 64'(bus_l.o_count), 64'd0);
    check_eq("rst_ready", 64'(rdy_seen),      64'd1);
    rst = 1'b0;

    // Basic record
    step(1'b1, 8'h11, 1'b0, 1'b1);
    check_eq("basic_cnt1", 64'(bus_l.o_count), 64'd1);
    step(1'b0, 8'hFF, 1'b1, 1'b1);
    check_eq("idle_cnt", 64'(bus_l.o_count), 64'd1);
    check_eq("idle_err", 64'(bus_l.o_error), 64'd0);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    check_eq("basic_cnt3", 64'(bus_l.o_count), 64'd3);
    check_eq("basic_nov",  64'(bus_l.o_valid), 64'd0);
    step(1'b1, 8'h44, 1'b1, 1'b1);
    check_rec("basic", 32'h44332211);
    check_eq("basic_err", 64'(bus_l.o_error), 64'd0);
    check_eq("basic_cnt0", 64'(bus_l.o_count), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("basic_1cyc", 64'(bus_l.o_valid), 64'd0);

    // Backpressure: record 1 held while record 2 fills behind it
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h23, 1'b0, 1'b0);
    step(1'b1, 8'h24, 1'b1, 1'b0);
    check_rec("bp_r1", 32'h24232221);
    step(1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b1, 8'h32, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check_eq("bp_cnt3", 64'(bus_l.o_count), 64'd3);
    step(1'b1, 8'h34, 1'b1, 1'b0);
    check_eq("bp_stall_rdy", 64'(rdy_seen), 64'd0);
    check_rec("bp_r1_hold", 32'h24232221);
    check_eq("bp_stall_cnt", 64'(bus_l.o_count), 64'd3);
    step(1'b1, 8'h34, 1'b1, 1'b0);
    check_eq("bp_stall_rdy2", 64'(rdy_seen), 64'd0);
    check_rec("bp_r1_hold2", 32'h24232221);
    step(1'b1, 8'h34, 1'b1, 1'b1);
    check_eq("bp_release_rdy", 64'(rdy_seen), 64'd1);
    check_rec("bp_r2", 32'h34333231);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("bp_drained", 64'(bus_l.o_valid), 64'd0);

    // Short frame
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b1, 8'hBB, 1'b1, 1'b1);
    check_eq("short_err",   64'(bus_l.o_error), 64'd1);
    check_eq("short_nov",   64'(bus_l.o_valid), 64'd0);
    check_eq("short_cnt",   64'(bus_l.o_count), 64'd0);
    step(1'b1, 8'h01, 1'b0, 1'b1);
    check_eq("short_pulse", 64'(bus_l.o_error), 64'd0);
    step(1'b1, 8'h02, 1'b0, 1'b1);
    step(1'b1, 8'h03, 1'b0, 1'b1);
    step(1'b1, 8'h04, 1'b1, 1'b1);
    check_rec("short_next", 32'h04030201);
    check_eq("short_next_err", 64'(bus_l.o_error), 64'd0);

    // Long frame
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h12, 1'b0, 1'b1);
    step(1'b1, 8'h13, 1'b0, 1'b1);
    check_rec("long_rec", 32'h13121110);
    check_eq("long_err", 64'(bus_l.o_error), 64'd1);
    step(1'b1, 8'h14, 1'b0, 1'b1);
    check_eq("drain_rdy",  64'(rdy_seen),       64'd1);
    check_eq("drain_err",  64'(bus_l.o_error),  64'd0);
    check_eq("drain_nov",  64'(bus_l.o_valid),  64'd0);
    check_eq("drain_cnt",  64'(bus_l.o_count),  64'd0);
    step(1'b1, 8'h15, 1'b1, 1'b1);
    check_eq("drain_cnt2", 64'(bus_l.o_count),  64'd0);
    check_eq("drain_err2", 64'(bus_l.o_error),  64'd0);
    step(1'b1, 8'h41, 1'b0, 1'b1);
    check_eq("resync_cnt", 64'(bus_l.o_count),  64'd1);
    step(1'b1, 8'h42, 1'b0, 1'b1);
    step(1'b1, 8'h43, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b1);
    check_rec("resync_rec", 32'h44434241);

    // Errors on consecutive cycles give separate pulses
    step(1'b1, 8'hE1, 1'b1, 1'b1);
    check_eq("dbl_err1", 64'(bus_l.o_error), 64'd1);
    step(1'b1, 8'hE2, 1'b1, 1'b1);
    check_eq("dbl_err2", 64'(bus_l.o_error), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check_eq("dbl_err_end", 64'(bus_l.o_error), 64'd0);

    // Reset mid-record with a held output record
    step(1'b1, 8'hC1, 1'b0, 1'b0);
    step(1'b1, 8'hC2, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 8'hC4, 1'b1, 1'b0);
    step(1'b1, 8'h91, 1'b0, 1'b0);
    step(1'b1, 8'h92, 1'b0, 1'b0);
    check_eq("prerst_cnt", 64'(bus_l.o_count), 64'd2);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    check_eq("midrst_cnt",   64'(bus_l.o_count), 64'd0);
    check_eq("midrst_valid", 64'(bus_l.o_valid), 64'd0);
    check_eq("midrst_data",  64'(bus_l.o_data),  64'd0);
    step(1'b1, 8'h55, 1'b0, 1'b1);
    check_eq("postrst_cnt", 64'(bus_l.o_count), 64'd1);
    step(1'b1, 8'h66, 1'b0, 1'b1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    step(1'b1, 8'h88, 1'b1, 1'b1);
    check_rec("postrst_rec", 32'h88776655);
    check_eq("postrst_err", 64'(bus_l.o_error), 64'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
